bit_place_encoder_fifo: RTL and testbench
=========================================

BIT_PLACE_ENCODER_FIFO -- requirements
Module: bit_place_encoder_fifo

Interface
REQ-001 Parameter DATA_W, default 8: activation value width; legal values are powers of two, 4 to 32.
REQ-002 Parameter IN_DEPTH, default 4: input value FIFO entries; legal values are powers of two, 2 or more.
REQ-003 Parameter OUT_DEPTH, default 8: output bit-place FIFO entries; legal values are powers of two, 2 or more.
REQ-004 Parameter SIGNED_MODE, default 0: 0 treats values as unsigned; 1 treats values as two's complement and encodes the magnitude.
REQ-005 PLACE_W SHALL equal clog2(DATA_W); it is derived and not overridable.
REQ-006 CLK  in  1  single clock; all state updates on the rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 ActValuesFIFOWriteDataIn  in  DATA_W  activation value to enqueue.
REQ-009 ActValuesFIFOWriteEnable  in  1  enqueue request.
REQ-010 ActValuesFIFOWriteReady  out  1  input FIFO not full.
REQ-011 ActBitPlacesFIFOReadEnable  in  1  dequeue request.
REQ-012 ActBitPlacesFIFOReadReady  out  1  output FIFO not empty.
REQ-013 ActBitPlacesFIFOReadDataOut  out  PLACE_W  bit place of the head entry.
REQ-014 ActBitPlacesFIFOReadLast  out  1  head entry is the final entry of its value.
REQ-015 ActBitPlacesFIFOReadSign  out  1  sign of the source value (always 0 when SIGNED_MODE=0).
REQ-016 ActBitPlacesFIFOReadZero  out  1  source value was zero; the place field is 0.
REQ-017 ActBitPlacesFIFOCount  out  clog2(OUT_DEPTH)+1  output FIFO occupancy.

Function
REQ-018 A write SHALL be accepted only on a cycle with WriteEnable=1 and WriteReady=1; a write while the FIFO is full SHALL be dropped with no state change.
REQ-019 The output FIFO SHALL be first-word-fall-through: while ReadReady=1, the ReadDataOut, Last, Sign and Zero outputs SHALL show the head entry combinationally from FIFO storage.
REQ-020 A read SHALL pop the head entry only when ReadEnable=1 and ReadReady=1; a read while the FIFO is empty SHALL be ignored.
REQ-021 The converter FSM SHALL have the states IDLE and SCAN.
REQ-022 In IDLE with the input FIFO non-empty, the FSM SHALL pop one value, load it into the mask register and go to SCAN.
REQ-023 In SIGNED_MODE=1 the FSM SHALL load the mask as |value| and latch sign = value MSB; for value -2^(DATA_W-1) the mask SHALL be exactly the single MSB bit.
REQ-024 In SCAN, each cycle the output FIFO is not full, the FSM SHALL emit one entry {place = index of lowest set mask bit, Last, Sign, Zero=0} and clear that mask bit.
REQ-025 Entries SHALL be emitted LSB first.
REQ-026 Last SHALL be 1 exactly when the remaining mask has one set bit.
REQ-027 A zero mask SHALL emit a single entry {place=0, Last=1, Zero=1, Sign=0}.
REQ-028 On the cycle a Last entry is emitted, if the input FIFO is non-empty the FSM SHALL load the next value in the same cycle (no bubble); otherwise it SHALL return to IDLE.
REQ-029 While the output FIFO is full the FSM SHALL stall and hold the mask; no entry SHALL be lost or duplicated.
REQ-030 A simultaneous emit and read on a full output FIFO SHALL stall the emit; the FIFO full condition SHALL be evaluated before the read.
REQ-031 Simultaneous push and pop on either FIFO when not full and not empty SHALL leave the count unchanged.
REQ-032 FIFO pointers SHALL wrap modulo depth.
REQ-033 Latency: a value written at edge E0 into an idle, empty design SHALL yield ReadReady=1 after edge E2.
REQ-034 Steady-state throughput SHALL be one entry per cycle.

Reset
REQ-035 While RST=1 at an edge: both FIFOs SHALL be emptied, the FSM SHALL go to IDLE, and the mask and sign SHALL clear.
REQ-036 Reset values: WriteReady=1, ReadReady=0, Count=0; DataOut, Last, Sign and Zero SHALL read 0.
REQ-037 A reset mid-SCAN SHALL discard the partial value; no entry of it SHALL appear after reset.
REQ-038 Writes and reads presented during reset SHALL be ignored.

Verification
REQ-039 Unsigned mode, write 0x12 -> entries (1,L0), (4,L1); ReadReady=1 two edges after the write.
REQ-040 Write 0x00, then 0x80 -> (0,Zero=1,L1), then (7,L1), with no idle cycle between them.
REQ-041 SIGNED_MODE=1, write 0xFF then 0x80 -> (0,S1,L1), then (7,S1,L1); writing 0x05 -> (0,S0,L0), (2,S0,L1).
REQ-042 OUT_DEPTH=8, write 0xFF and 0xFF with no reads -> Count stops at 8 and the FSM stalls; then read continuously -> 16 entries, places 0..7 twice in order, Last on the 8th and 16th.
REQ-043 Fill the input FIFO with IN_DEPTH values while the FSM is stalled; one more write -> it is dropped and WriteReady=0.
REQ-044 Assert RST mid-SCAN of 0xF0 after 2 entries are emitted -> Count=0 and ReadReady=0; after reset a write of 0x01 yields only (0,L1).

Source files
------------

// File: rtl/bit_place_encoder_fifo.sv
// Converts activation values into a stream of set-bit positions (LSB first),
// buffered by an input value FIFO and a first-word-fall-through output FIFO.
module bit_place_encoder_fifo #(
    parameter int DATA_W      = 8,
    parameter int IN_DEPTH    = 4,
    parameter int OUT_DEPTH   = 8,
    parameter int SIGNED_MODE = 0,
    localparam int PLACE_W    = $clog2(DATA_W)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [DATA_W-1:0]            ActValuesFIFOWriteDataIn,
    input  logic                         ActValuesFIFOWriteEnable,
    output logic                         ActValuesFIFOWriteReady,
    input  logic                         ActBitPlacesFIFOReadEnable,
    output logic                         ActBitPlacesFIFOReadReady,
    output logic [PLACE_W-1:0]           ActBitPlacesFIFOReadDataOut,
    output logic                         ActBitPlacesFIFOReadLast,
    output logic                         ActBitPlacesFIFOReadSign,
    output logic                         ActBitPlacesFIFOReadZero,
    output logic [$clog2(OUT_DEPTH):0]   ActBitPlacesFIFOCount
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int ENT_W  = PLACE_W + 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // ---------------- input value FIFO ----------------
    logic [DATA_W-1:0] in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  in_wr_q, in_rd_q;
    logic [IN_AW:0]    in_cnt_q;
    logic              in_full, in_not_empty, in_push, in_pop;
    logic [DATA_W-1:0] in_head;

    assign in_full      = (in_cnt_q == (IN_AW+1)'(IN_DEPTH));
    assign in_not_empty = (in_cnt_q != '0);
    assign in_push      = ActValuesFIFOWriteEnable && !in_full && !RST;
    assign in_head      = in_mem[in_rd_q];

    always_ff @(posedge CLK) begin
        if (in_push) begin
            in_mem[in_wr_q] <= ActValuesFIFOWriteDataIn;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_wr_q  <= '0;
            in_rd_q  <= '0;
            in_cnt_q <= '0;
        end else begin
            if (in_push) in_wr_q <= in_wr_q + 1'b1;
            if (in_pop)  in_rd_q <= in_rd_q + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_cnt_q <= in_cnt_q + 1'b1;
                2'b01:   in_cnt_q <= in_cnt_q - 1'b1;
                default: in_cnt_q <= in_cnt_q;
            endcase
        end
    end

    // ---------------- load path: magnitude and sign of the head value ----------------
    logic [DATA_W-1:0] load_mask;
    logic              load_sign;

    generate
        if (SIGNED_MODE != 0) begin : g_signed
            // Negating the most negative value wraps back to the lone MSB, which is its magnitude.
            assign load_sign = in_head[DATA_W-1];
            assign load_mask = load_sign ? (~in_head + DATA_W'(1)) : in_head;
        end else begin : g_unsigned
            assign load_sign = 1'b0;
            assign load_mask = in_head;
        end
    endgenerate

    // ---------------- converter FSM ----------------
    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic              sign_q, sign_d;
    logic [DATA_W-1:0] mask_rest;
    logic              scan_last, scan_zero, emit;
    logic [PLACE_W-1:0] scan_place;
    logic              out_full, out_not_empty, out_pop;

    assign mask_rest = mask_q & (mask_q - DATA_W'(1));
    assign scan_last = (mask_rest == '0);
    assign scan_zero = (mask_q == '0);
    assign emit      = (state_q == ST_SCAN) && !out_full;
    assign in_pop    = in_not_empty && ((state_q == ST_IDLE) || (emit && scan_last));

    always_comb begin
        scan_place = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (mask_q[i]) scan_place = PLACE_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sign_d  = sign_q;
        if (in_pop) begin
            state_d = ST_SCAN;
            mask_d  = load_mask;
            sign_d  = load_sign;
        end else if (emit) begin
            if (scan_last) begin
                state_d = ST_IDLE;
                mask_d  = '0;
                sign_d  = 1'b0;
            end else begin
                mask_d  = mask_rest;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sign_q  <= sign_d;
        end
    end

    // ---------------- output bit-place FIFO (first-word fall-through) ----------------
    logic [ENT_W-1:0]  out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_q, out_rd_q;
    logic [OUT_AW:0]   out_cnt_q;
    logic [ENT_W-1:0]  out_wdata, out_head;

    assign out_full      = (out_cnt_q == (OUT_AW+1)'(OUT_DEPTH));
    assign out_not_empty = (out_cnt_q != '0);
    assign out_pop       = ActBitPlacesFIFOReadEnable && out_not_empty;
    assign out_wdata     = {scan_place, scan_last, sign_q, scan_zero};

    always_ff @(posedge CLK) begin
        if (emit) begin
            out_mem[out_wr_q] <= out_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (emit)    out_wr_q <= out_wr_q + 1'b1;
            if (out_pop) out_rd_q <= out_rd_q + 1'b1;
            case ({emit, out_pop})
                2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
                2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    // Empty FIFO presents all-zero fields rather than stale storage.
    assign out_head = out_not_empty ? out_mem[out_rd_q] : '0;

    assign ActValuesFIFOWriteReady     = !in_full;
    assign ActBitPlacesFIFOReadReady   = out_not_empty;
    assign ActBitPlacesFIFOReadDataOut = out_head[ENT_W-1:3];
    assign ActBitPlacesFIFOReadLast    = out_head[2];
    assign ActBitPlacesFIFOReadSign    = out_head[1];
    assign ActBitPlacesFIFOReadZero    = out_head[0];
    assign ActBitPlacesFIFOCount       = out_cnt_q;

endmodule

// File: tb/tb_bit_place_encoder_fifo.sv
// Bench for bit_place_encoder_fifo: unsigned and signed instances, a queue model of the
// expected entry stream checked on every pop, plus literal timing/occupancy checks.
module tb_bit_place_encoder_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       wen_u, wen_s, ren_u, ren_s;

    logic       wr_rdy_u, rd_rdy_u, last_u, sign_u, zero_u;
    logic [2:0] dout_u;
    logic [3:0] cnt_u;
    logic       wr_rdy_s, rd_rdy_s, last_s, sign_s, zero_s;
    logic [2:0] dout_s;
    logic [3:0] cnt_s;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    // entry = {place[2:0], last, sign, zero}
    logic [5:0] expq_u[$];
    logic [5:0] expq_s[$];
    logic [5:0] exp_u, exp_s;

    bit_place_encoder_fifo #(.DATA_W(8), .IN_DEPTH(4), .OUT_DEPTH(8), .SIGNED_MODE(0)) u_dut (
        .CLK                         (clk),
        .RST                         (rst),
        .ActValuesFIFOWriteDataIn    (din),
        .ActValuesFIFOWriteEnable    (wen_u),
        .ActValuesFIFOWriteReady     (wr_rdy_u),
        .ActBitPlacesFIFOReadEnable  (ren_u),
        .ActBitPlacesFIFOReadReady   (rd_rdy_u),
        .ActBitPlacesFIFOReadDataOut (dout_u),
        .ActBitPlacesFIFOReadLast    (last_u),
        .ActBitPlacesFIFOReadSign    (sign_u),
        .ActBitPlacesFIFOReadZero    (zero_u),
        .ActBitPlacesFIFOCount       (cnt_u)
    );

    bit_place_encoder_fifo #(.DATA_W(8), .IN_DEPTH(4), .OUT_DEPTH(8), .SIGNED_MODE(1)) s_dut (
        .CLK                         (clk),
        .RST                         (rst),
        .ActValuesFIFOWriteDataIn    (din),
        .ActValuesFIFOWriteEnable    (wen_s),
        .ActValuesFIFOWriteReady     (wr_rdy_s),
        .ActBitPlacesFIFOReadEnable  (ren_s),
        .ActBitPlacesFIFOReadReady   (rd_rdy_s),
        .ActBitPlacesFIFOReadDataOut (dout_s),
        .ActBitPlacesFIFOReadLast    (last_s),
        .ActBitPlacesFIFOReadSign    (sign_s),
        .ActBitPlacesFIFOReadZero    (zero_s),
        .ActBitPlacesFIFOCount       (cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Expected entries of one value: set bits of its magnitude, LSB first.
    task automatic model_push(input bit s, input logic [7:0] v);
        logic [7:0] mag;
        logic       sg;
        logic [5:0] e;
        sg  = s && v[7];
        mag = sg ? (8'd0 - v) : v;
        if (mag == 8'd0) begin
            e = {3'd0, 1'b1, 1'b0, 1'b1};
            if (s) expq_s.push_back(e); else expq_u.push_back(e);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (mag[i]) begin
                    e = {3'(i), ((mag >> (i + 1)) == 8'd0), sg, 1'b0};
                    if (s) expq_s.push_back(e); else expq_u.push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input bit s, input logic [7:0] v, input bit accept);
        din = v;
        if (s) wen_s = 1'b1; else wen_u = 1'b1;
        if (accept) model_push(s, v);
        tick();
        wen_s = 1'b0;
        wen_u = 1'b0;
    endtask

    task automatic drain(input bit s, output int cycles);
        cycles = 0;
        if (s) ren_s = 1'b1; else ren_u = 1'b1;
        while (((s ? expq_s.size() : expq_u.size()) > 0) && cycles < 200) begin
            tick();
            cycles++;
        end
        ren_s = 1'b0;
        ren_u = 1'b0;
        if ((s ? expq_s.size() : expq_u.size()) > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d entries left required 0", s ? expq_s.size() : expq_u.size());
        end
    endtask

    // Every pop is checked against the head of the model queue.
    always @(negedge clk) begin
        if (!rst && ren_u && rd_rdy_u) begin
            if (expq_u.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL uns_extra_entry: got %b required none", {dout_u, last_u, sign_u, zero_u});
            end else begin
                exp_u = expq_u.pop_front();
                chk("uns_pop_entry", {26'd0, dout_u, last_u, sign_u, zero_u}, {26'd0, exp_u});
            end
        end
        if (!rst && ren_s && rd_rdy_s) begin
            if (expq_s.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sgn_extra_entry: got %b required none", {dout_s, last_s, sign_s, zero_s});
            end else begin
                exp_s = expq_s.pop_front();
                chk("sgn_pop_entry", {26'd0, dout_s, last_s, sign_s, zero_s}, {26'd0, exp_s});
            end
        end
    end

    initial begin
        rst = 1'b1; din = 8'd0;
        wen_u = 1'b0; wen_s = 1'b0; ren_u = 1'b0; ren_s = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_wr_ready_u", wr_rdy_u, 1);
        chk("rst_rd_ready_u", rd_rdy_u, 0);
        chk("rst_count_u", cnt_u, 0);
        chk("rst_fields_u", {dout_u, last_u, sign_u, zero_u}, 0);
        chk("rst_wr_ready_s", wr_rdy_s, 1);
        chk("rst_rd_ready_s", rd_rdy_s, 0);
        chk("rst_count_s", cnt_s, 0);
        chk("rst_fields_s", {dout_s, last_s, sign_s, zero_s}, 0);

        // 0x12: ready two edges after the write, entries (1,L0),(4,L1)
        write(0, 8'h12, 1);
        chk("lat_after_e0", rd_rdy_u, 0);
        tick();
        chk("lat_after_e1", rd_rdy_u, 0);
        tick();
        chk("lat_after_e2", rd_rdy_u, 1);
        chk("x12_head", {dout_u, last_u, sign_u, zero_u}, 6'b001_0_0_0);
        chk("x12_count1", cnt_u, 1);
        tick();
        chk("x12_count2", cnt_u, 2);
        drain(0, cyc);
        chk("x12_drain_cycles", cyc, 2);
        chk("x12_empty", rd_rdy_u, 0);

        // 0x00 then 0x80 back to back: zero entry then (7,L1), no bubble
        write(0, 8'h00, 1);
        write(0, 8'h80, 1);
        tick();
        chk("zero_count1", cnt_u, 1);
        chk("zero_head", {dout_u, last_u, sign_u, zero_u}, 6'b000_1_0_1);
        tick();
        chk("nobubble_count2", cnt_u, 2);
        drain(0, cyc);

        // Signed: 0xFF, 0x80, 0x05
        write(1, 8'hFF, 1);
        write(1, 8'h80, 1);
        write(1, 8'h05, 1);
        chk("sgn_ff_head", {dout_s, last_s, sign_s, zero_s}, 6'b000_1_1_0);
        tick();
        chk("sgn_count2", cnt_s, 2);
        drain(1, cyc);
        chk("sgn_empty", rd_rdy_s, 0);

        // Output FIFO full stall, then input FIFO full and a dropped write
        write(0, 8'hFF, 1);
        write(0, 8'hFF, 1);
        repeat (12) tick();
        chk("stall_count8", cnt_u, 8);
        chk("stall_wr_ready", wr_rdy_u, 1);
        write(0, 8'h01, 1);
        write(0, 8'h02, 1);
        write(0, 8'h03, 1);
        write(0, 8'h00, 1);
        chk("infull_wr_ready0", wr_rdy_u, 0);
        write(0, 8'h55, 0);
        chk("drop_wr_ready0", wr_rdy_u, 0);
        chk("drop_count8", cnt_u, 8);
        chk("stall_head", {dout_u, last_u, sign_u, zero_u}, 6'b000_0_0_0);
        drain(0, cyc);
        chk("throughput_cycles", cyc, 21);
        chk("stall_empty", rd_rdy_u, 0);
        chk("stall_wr_ready1", wr_rdy_u, 1);

        // Reset mid-SCAN of 0xF0 after two entries; a write held during reset is ignored
        write(0, 8'hF0, 1);
        repeat (3) tick();
        chk("midscan_count2", cnt_u, 2);
        rst = 1'b1;
        din = 8'h77;
        wen_u = 1'b1;
        expq_u.delete();
        expq_s.delete();
        tick();
        chk("midrst_count0", cnt_u, 0);
        chk("midrst_rd_ready0", rd_rdy_u, 0);
        chk("midrst_fields0", {dout_u, last_u, sign_u, zero_u}, 0);
        rst = 1'b0;
        wen_u = 1'b0;
        repeat (4) tick();
        chk("postrst_rd_ready0", rd_rdy_u, 0);
        chk("postrst_count0", cnt_u, 0);
        write(0, 8'h01, 1);
        tick();
        tick();
        chk("postrst_head", {dout_u, last_u, sign_u, zero_u}, 6'b000_1_0_0);
        chk("postrst_count1", cnt_u, 1);
        drain(0, cyc);
        tick();
        chk("final_empty_u", rd_rdy_u, 0);
        chk("final_empty_s", rd_rdy_s, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
